shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Command-driven sequencer for the team's 4-bit shift-register datapath.
- Accepts one transfer command at a time over a valid/ready handshake and emits one-hot load/shift/capture strobes cycle by cycle.
- Counts shift cycles and reports completion.
- Sits between the host/bus-side logic and the shift-register datapath. It owns all timing of that datapath.

Parameters:
- WIDTH, 4, datapath width; also the default shift count.
- LEN_W, 3, width of cmd_len; the maximum programmable shift count is 2^LEN_W-1.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  0 = serial-in serial-out, 1 = parallel-in serial-out, 2 = serial-in parallel-out, 3 = parallel-in parallel-out.
- cmd_len  in  LEN_W  number of shift cycles; 0 means WIDTH.
- stall  in  1  pauses shifting; the counter holds.
- abort  in  1  synchronous cancel of the current command.
- sr_load  out  1  strobe to the datapath: parallel load.
- sr_shift  out  1  strobe to the datapath: one serial shift.
- sr_cap  out  1  strobe to the datapath: parallel output capture.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- aborted  out  1  one-cycle pulse when a command is cancelled.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE; op and count registers clear.
  - sr_load=sr_shift=sr_cap=0, done=aborted=0, busy=0, cmd_ready=0 while RST is held.
  - cmd_ready rises on the first clock after release.
- All outputs are registered-state decodes. No combinational path from cmd_valid to any strobe.
- States: IDLE, LOAD, SHIFT, CAPT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op and cnt (cnt = cmd_len, or WIDTH if cmd_len=0).
  - Next state: op=1 -> LOAD; op=0 or 2 -> SHIFT; op=3 -> CAPT.
- LOAD:
  - sr_load=1 for exactly one cycle, then SHIFT.
- SHIFT:
  - sr_shift = ~stall.
  - When not stalled, cnt decrements.
  - On the unstalled cycle with cnt==1: op=2 -> CAPT; else -> DONE.
  - stall=1 holds the state and cnt, with no strobe.
- CAPT:
  - sr_cap=1 for exactly one cycle, then DONE. stall is ignored.
- DONE:
  - done=1 for one cycle, then IDLE.
  - cmd_ready is 0 in DONE, so back-to-back commands have a one-cycle gap.
- Latency, with command accepted at cycle T and no stall, for length L:
  - op0: shifts T+1..T+L; done at T+L+1.
  - op1: load T+1; shifts T+2..T+L+1; done T+L+2.
  - op2: shifts T+1..T+L; cap T+L+1; done T+L+2.
  - op3: cap T+1; done T+2.
- abort:
  - In LOAD, SHIFT or CAPT: the next state is IDLE, no strobe is issued that cycle, aborted=1 next cycle, and done is never asserted.
  - Ignored in IDLE and DONE.
  - abort has priority over stall and over the cnt==1 transition.
- Simultaneous stall and abort: abort wins.
- cmd_valid while busy is not accepted; the command must be held until cmd_ready.
- At most one of sr_load, sr_shift and sr_cap is high in any cycle.
- cnt is LEN_W bits and never wraps: cnt==0 is unreachable in SHIFT.
- Asynchronous reset mid-command drops all strobes immediately. No done or aborted pulse is produced.

Decomposition:
- Shared package shift_pkg holds:
  - the op encoding constants OP_SISO=0, OP_PISO=1, OP_SIPO=2, OP_PIPO=3;
  - the state encoding for IDLE/LOAD/SHIFT/CAPT/DONE;
  - the WIDTH default.
- One sub-module is natural: shift_cnt, a loadable down-counter with enable and a last (cnt==1) flag.

Test Plan:
- Reset, then op=1 with len=0 (WIDTH=4) -> sr_load at T+1; sr_shift at T+2..T+5; done at T+6; cmd_ready high at T+7.
- op=2 with len=3 and stall high for 2 cycles after the first shift -> exactly 3 sr_shift pulses over 5 cycles; sr_cap one cycle after the last shift; then done.
- op=3 -> sr_cap at T+1 and done at T+2; no sr_shift or sr_load at any point.
- op=0 with len=7, abort asserted on the 4th shift cycle -> 3 shifts only; aborted pulse next cycle; no done; IDLE after.
- cmd_valid held continuously with two queued commands (op0 len 2, then op3) -> the second is accepted only on the cycle after done; strobes are never overlapping.
- RST driven low asynchronously mid-SHIFT between clock edges -> strobes and busy go to 0 immediately; after release, cmd_ready=1 and a fresh op=1 command sequences correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the shift-register sequencer: op codes, FSM states
// and the default datapath width.
package shift_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_SISO = 2'd0,
    OP_PISO = 2'd1,
    OP_SIPO = 2'd2,
    OP_PIPO = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // The first active phase that follows a command acceptance.
  function automatic state_e first_state(op_e op);
    case (op)
      OP_PISO: first_state = ST_LOAD;
      OP_PIPO: first_state = ST_CAPT;
      default: first_state = ST_SHIFT;
    endcase
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command handshake between the host side (master) and the sequencer (slave).
interface shift_seq_ctrl_if #(
  parameter int LEN_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_len, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_len, output cmd_ready);
endinterface

// File: rtl/shift_cnt.sv
// Loadable down-counter for shift cycles; o_last flags the final shift.
module shift_cnt #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_last
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (i_load)               r_cnt <= i_val;
    else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - W'(1);
  end

  assign o_last = (r_cnt == W'(1));
endmodule

// File: rtl/shift_seq_ctrl.sv
// Command-driven sequencer that times the load/shift/capture strobes of the
// shift-register datapath and reports completion or cancellation.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  shift_seq_ctrl_if.slave   bus,
  input  logic              stall,
  input  logic              abort,
  output logic              sr_load,
  output logic              sr_shift,
  output logic              sr_cap,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  state_e           r_state;
  op_e              r_op;
  logic             r_ready;
  logic             r_aborted;

  logic             w_accept;
  logic             w_live;
  logic             w_cancel;
  logic             w_step;
  logic             w_last;
  logic [LEN_W-1:0] w_len;

  assign w_len    = (bus.cmd_len == '0) ? LEN_W'(WIDTH) : bus.cmd_len;
  assign w_accept = (r_state == ST_IDLE) && r_ready && bus.cmd_valid;
  assign w_live   = (r_state == ST_LOAD) || (r_state == ST_SHIFT) || (r_state == ST_CAPT);
  assign w_cancel = w_live && abort;
  assign w_step   = (r_state == ST_SHIFT) && !stall && !abort;

  shift_cnt #(.W(LEN_W)) u_cnt (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (w_accept),
    .i_val   (w_len),
    .i_en    (w_step),
    .o_last  (w_last)
  );

  // r_ready stays low through reset and comes up on the first clock after it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_SISO;
      r_ready   <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= 1'b0;
      if (w_cancel) begin
        r_state   <= ST_IDLE;
        r_ready   <= 1'b1;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_op    <= op_e'(bus.cmd_op);
              r_state <= first_state(op_e'(bus.cmd_op));
              r_ready <= 1'b0;
            end else begin
              r_ready <= 1'b1;
            end
          end
          ST_LOAD:  r_state <= ST_SHIFT;
          ST_SHIFT: begin
            if (!stall && w_last)
              r_state <= (r_op == OP_SIPO) ? ST_CAPT : ST_DONE;
          end
          ST_CAPT:  r_state <= ST_DONE;
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.cmd_ready = r_ready;
  assign sr_load  = (r_state == ST_LOAD) && !abort;
  assign sr_shift = w_step;
  assign sr_cap   = (r_state == ST_CAPT) && !abort;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign aborted  = r_aborted;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed scenarios plus random traffic, all
// checked against a phase-script model of each command.
module tb_shift_seq_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic stall = 1'b0, abort = 1'b0;
  logic sr_load, sr_shift, sr_cap, busy, done, aborted;

  always #5 CLK = ~CLK;

  shift_seq_ctrl_if #(.LEN_W(3)) bif ();

  shift_seq_ctrl #(.WIDTH(4), .LEN_W(3)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bif),
    .stall    (stall),
    .abort    (abort),
    .sr_load  (sr_load),
    .sr_shift (sr_shift),
    .sr_cap   (sr_cap),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  // Phase codes for the per-command script.
  localparam int PH_L = 1, PH_S = 2, PH_C = 3, PH_D = 4;

  int n_chk = 0, n_err = 0;
  int q[$];
  bit m_rdy = 0, m_ab = 0, m_acc = 0;
  int n_shift = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_cmd(int op, int len);
    int l = (len == 0) ? 4 : len;
    if (op == 1) q.push_back(PH_L);
    if (op != 3) for (int i = 0; i < l; i++) q.push_back(PH_S);
    if (op == 2 || op == 3) q.push_back(PH_C);
    q.push_back(PH_D);
  endfunction

  task automatic step(bit v, int op, int len, bit st, bit ab, bit rv = 1'b1);
    int  front;
    bit  was_empty, nab;
    logic [6:0] exp_v;
    @(negedge CLK);
    RST = rv;
    bif.cmd_valid = v;
    bif.cmd_op    = op[1:0];
    bif.cmd_len   = len[2:0];
    stall = st;
    abort = ab;
    #1;
    front     = (q.size() != 0) ? q[0] : 0;
    was_empty = (q.size() == 0);
    exp_v = {front == PH_L && !ab,
             front == PH_S && !st && !ab,
             front == PH_C && !ab,
             front == PH_D,
             m_ab,
             !was_empty,
             m_rdy && was_empty};
    chk("outs", 32'({sr_load, sr_shift, sr_cap, done, aborted, busy, bif.cmd_ready}), 32'(exp_v));
    chk("onehot", 32'($countones({sr_load, sr_shift, sr_cap}) > 1), 32'(0));
    if (sr_shift) n_shift++;
    m_acc = 0;
    if (!RST) begin
      q.delete();
      m_rdy = 0;
      m_ab  = 0;
    end else begin
      nab = ab && (front == PH_L || front == PH_S || front == PH_C);
      if (nab) q.delete();
      else if (!was_empty && !(front == PH_S && st)) void'(q.pop_front());
      if (was_empty && m_rdy && v) begin
        push_cmd(op, len);
        m_acc = 1;
      end
      m_ab  = nab;
      m_rdy = 1;
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic send(int op, int len);
    for (int i = 0; i < 40; i++) begin
      step(1, op, len, 0, 0);
      if (m_acc) return;
    end
    chk("accept_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = 2'd0;
    bif.cmd_len   = 3'd0;
    repeat (3) step(0, 0, 0, 0, 0, 1'b0);

    // PISO with default length.
    idle(1);
    send(1, 0);
    idle(8);

    // SIPO len 3 with a two-cycle stall after the first shift.
    send(2, 3);
    n_shift = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    idle(6);
    chk("sipo_shifts", 32'(n_shift), 32'(3));

    // PIPO: capture then done, nothing else.
    n_shift = 0;
    send(3, 0);
    idle(4);
    chk("pipo_shifts", 32'(n_shift), 32'(0));

    // SISO len 7 aborted on the fourth shift cycle.
    send(0, 7);
    n_shift = 0;
    idle(3);
    step(0, 0, 0, 0, 1);
    idle(4);
    chk("abort_shifts", 32'(n_shift), 32'(3));

    // Abort while stalled, then during load and capture.
    send(0, 5);
    step(0, 0, 0, 1, 1);
    idle(2);
    send(1, 2);
    step(0, 0, 0, 0, 1);
    idle(2);
    send(3, 0);
    step(0, 0, 0, 0, 1);
    idle(2);

    // Back-to-back queued commands with valid held high.
    send(0, 2);
    send(3, 0);
    idle(5);

    // Asynchronous reset in the middle of shifting.
    send(1, 0);
    idle(3);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("arst_outs", 32'({sr_load, sr_shift, sr_cap, busy, done, aborted, bif.cmd_ready}), 32'(0));
    q.delete();
    m_rdy = 0;
    m_ab  = 0;
    step(0, 0, 0, 0, 0, 1'b0);
    step(0, 0, 0, 0, 0, 1'b0);
    step(0, 0, 0, 0, 0, 1'b1);
    send(1, 3);
    idle(8);

    // Random traffic; a command is held until the model sees it accepted.
    begin
      bit pend = 0;
      int rop = 0, rlen = 0;
      for (int c = 0; c < 3000; c++) begin
        if (!pend && $urandom_range(0, 3) == 0) begin
          pend = 1;
          rop  = int'($urandom_range(0, 3));
          rlen = int'($urandom_range(0, 7));
        end
        step(pend, rop, rlen, $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
        if (m_acc) pend = 0;
      end
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
